// File: rtl/add_arb_pkg.sv
// Shared constants and helpers for the add_arbiter slice (round-robin search, ID width).
// Optional subtract support is enabled by defining ADD_ARB_SUB_EN.
package add_arb_pkg;

    localparam int unsigned ADD_W   = 32;
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned MAX_IDW = 3;

    // Width of a requester index; a single requester still gets one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One-hot grant of the first valid requester at or after ptr, wrapping mod n.
    function automatic logic [MAX_REQ-1:0] rr_grant(
        input logic [MAX_IDW-1:0] ptr,
        input logic [MAX_REQ-1:0] valid,
        input int unsigned        n
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int unsigned        idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = (32'(ptr) + k) % n;
            if (k < n && !found && valid[idx[MAX_IDW-1:0]]) begin
                grant[idx[MAX_IDW-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/bk_adder32.sv
// Brent-Kung parallel-prefix adder; carry-in folded into bit 0 generate.
module bk_adder32
    import add_arb_pkg::*;
#(
    parameter int unsigned W = ADD_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int LVL = $clog2(W);

    logic [W-1:0] prop;
    logic [W-1:0] gp;
    logic [W-1:0] pp;

    always_comb begin
        prop  = a ^ b;
        gp    = a & b;
        pp    = prop;
        gp[0] = gp[0] | (pp[0] & cin);
        // Up-sweep: build group terms at power-of-two boundaries.
        for (int l = 0; l < LVL; l++) begin
            for (int i = (2 << l) - 1; i < int'(W); i += (2 << l)) begin
                gp[i] = gp[i] | (pp[i] & gp[i - (1 << l)]);
                pp[i] = pp[i] & pp[i - (1 << l)];
            end
        end
        // Down-sweep: fill in the remaining prefix positions.
        for (int l = LVL - 2; l >= 0; l--) begin
            for (int i = 3 * (1 << l) - 1; i < int'(W); i += (2 << l)) begin
                gp[i] = gp[i] | (pp[i] & gp[i - (1 << l)]);
                pp[i] = pp[i] & pp[i - (1 << l)];
            end
        end
        sum  = prop ^ {gp[W-2:0], cin};
        cout = gp[W-1];
    end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one prefix adder between NREQ requesters, single-entry output stage.
// Define ADD_ARB_SUB_EN to add the per-requester req_sub input (a + ~b + 1).
module add_arbiter
    import add_arb_pkg::*;
#(
    parameter  int unsigned NREQ  = 3,
    parameter  int unsigned WIDTH = ADD_W,
    localparam int unsigned IDW   = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
`ifdef ADD_ARB_SUB_EN
    input  logic [NREQ-1:0]       req_sub,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout
);

    logic [IDW-1:0]   ptr;
    logic             free_c;
    logic [NREQ-1:0]  grant_c;
    logic [IDW-1:0]   gidx_c;
    logic [IDW-1:0]   ptr_next_c;
    logic [WIDTH-1:0] a_sel_c;
    logic [WIDTH-1:0] b_sel_c;
    logic             cin_sel_c;
    logic [WIDTH-1:0] b_op_c;
    logic             cin_op_c;
    logic [WIDTH-1:0] sum_c;
    logic             cout_c;

    // Slot is free when empty or being drained this cycle; no grant during reset.
    assign free_c    = !rsp_valid || rsp_ready;
    assign grant_c   = (rst || !free_c) ? '0
                     : NREQ'(rr_grant(MAX_IDW'(ptr), MAX_REQ'(req_valid), NREQ));
    assign req_ready = grant_c;

    // Operand mux driven by the one-hot grant.
    always_comb begin
        gidx_c    = '0;
        a_sel_c   = '0;
        b_sel_c   = '0;
        cin_sel_c = 1'b0;
        b_op_c    = '0;
        cin_op_c  = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant_c[i]) begin
                gidx_c    = IDW'(i);
                a_sel_c   = req_a[i*WIDTH +: WIDTH];
                b_sel_c   = req_b[i*WIDTH +: WIDTH];
                cin_sel_c = req_cin[i];
            end
        end
`ifdef ADD_ARB_SUB_EN
        b_op_c   = ((grant_c & req_sub) != '0) ? ~b_sel_c : b_sel_c;
        cin_op_c = ((grant_c & req_sub) != '0) ? 1'b1 : cin_sel_c;
`else
        b_op_c   = b_sel_c;
        cin_op_c = cin_sel_c;
`endif
    end

    assign ptr_next_c = (gidx_c == IDW'(NREQ - 1)) ? '0 : gidx_c + IDW'(1);

    bk_adder32 #(
        .W (WIDTH)
    ) u_adder (
        .a    (a_sel_c),
        .b    (b_op_c),
        .cin  (cin_op_c),
        .sum  (sum_c),
        .cout (cout_c)
    );

    // Output stage and round-robin pointer; pointer moves only on a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= '0;
            ptr       <= '0;
        end else if (grant_c != '0) begin
            rsp_valid <= 1'b1;
            rsp_sum   <= sum_c;
            rsp_cout  <= cout_c;
            rsp_id    <= gidx_c;
            ptr       <= ptr_next_c;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: doc/add_arbiter.md
# add_arbiter

Round-robin arbiter that shares one 32-bit prefix adder between NREQ requesters (ALU, branch-target, address-generation). Each requester presents operands with a valid/ready handshake. The arbiter grants one request per cycle and registers the adder result into a single-entry output stage tagged with the requester ID. It sits in the execute stage between the issue logic and the shared adder.

## Interface
- NREQ, 3, number of requesters (2..8)
- WIDTH, 32, operand width
- IDW, $clog2(NREQ), requester ID width (derived, not overridden)

- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester grant; handshake when valid&ready
- req_a  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B, same packing
- req_cin  in  NREQ  carry-in per requester
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  index of the requester whose result is presented
- rsp_sum  out  WIDTH  registered sum
- rsp_cout  out  1  registered carry-out

## Operation
- Slot free: free = !rsp_valid || rsp_ready.
- Grant: if free, grant the first requester with req_valid=1, searching from ptr upward with wrap mod NREQ. At most one req_ready bit is high. All req_ready are 0 when not free.
- req_ready depends combinationally on req_valid and rsp_ready. Requesters must not derive req_valid from req_ready.
- A requester holds req_valid and its operands stable until accepted.
- On handshake of requester g, on the next clk:
  - rsp_sum/rsp_cout = adder(a_g, b_g, cin_g)
  - rsp_id = g
  - rsp_valid = 1
  - ptr = (g+1) mod NREQ
- Drain: rsp_ready=1 with no new grant → rsp_valid = 0 next cycle.
- Drain and grant in the same cycle: the output reloads with the new result and rsp_valid stays 1, giving full throughput.
- Backpressure: rsp_valid=1 with rsp_ready=0 → output registers hold, ptr holds, no grant.
- ptr advances only on a grant, never on idle cycles.
- Arithmetic: modulo 2^WIDTH. rsp_cout is the carry out of bit WIDTH-1.

## Timing
- Latency: request accepted in cycle N → result visible in cycle N+1.
- Throughput: one result per cycle while rsp_ready=1.
- Reset values: rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, ptr=0. req_ready is combinational and is 0 while rsp is stalled.
- Reset mid-operation: a pending result is discarded. No grant is issued in the cycle rst is high (req_ready forced 0).
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 grants.

## Configuration
- ADD_ARB_SUB_EN defined: adds input `req_sub` [NREQ].
  - A handshaked request with req_sub=1 computes a + ~b + 1; req_cin is ignored.
  - rsp_cout is the subtract carry (1 means no borrow).
- Macro undefined: port absent; always a + b + cin.

## Structure
- Package add_arb_pkg holds:
  - ADD_W = 32
  - a function for the round-robin next-grant search (ptr, valid vector → one-hot grant)
  - the ID width helper
- One sub-module: bk_adder32, a single instance fed by the granted requester's muxed operands.
- Output register, pointer and mux stay in add_arbiter.

## Test plan
- Single request: req0 a=0x0000_0005, b=0x0000_0003, cin=0 → next cycle rsp_valid=1, rsp_sum=0x8, rsp_cout=0, rsp_id=0.
- Carry/wrap: req2 a=0xFFFF_FFFF, b=0x0000_0001, cin=0 → rsp_sum=0x0, rsp_cout=1, rsp_id=2. Then a=b=0xFFFF_FFFF, cin=1 → rsp_sum=0xFFFF_FFFF, cout=1.
- Fairness: all three requesters always valid, rsp_ready=1 → rsp_id sequence 0,1,2,0,1,2, one result per cycle.
- Backpressure: rsp_ready=0 for 4 cycles with req1 pending → req_ready=0 and rsp fields stable. rsp_ready=1 → req1 granted that cycle, its result appears next cycle.
- Reset mid-flight: rst=1 while rsp_valid=1 → next cycle rsp_valid=0, ptr=0. After release, a request from req1 is granted first.
- ADD_ARB_SUB_EN: req0 a=10, b=3, req_sub=1 → rsp_sum=7, rsp_cout=1. a=3, b=10 → rsp_sum=0xFFFF_FFF9, rsp_cout=0.
